// File: rtl/ss_axi_lite_slave.sv
// ss_axi_lite_slave: AXI4-Lite register bank for the SS peripheral.
// Four 32-bit registers in word slots 0-3; slots 4-7 are unmapped.
// Optional macro SS_AXI_SLVERR_EN: unmapped accesses answer SLVERR
// instead of OKAY (still no side effects, reads still return zero).
`timescale 1ns/1ps

module ss_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                          active;
  logic                          aw_full;
  logic                          w_full;
  logic [IDX_W-1:0]              aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]             w_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          commit;
  logic                          wr_mapped;
  logic                          rd_mapped;
  logic [IDX_W-1:0]              ar_idx;
  logic [1:0]                    wr_resp_code;
  logic [1:0]                    rd_resp_code;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                          unused_bits;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies stay low until the first clock after reset release, so the
  // interface never advertises acceptance while reset is asserted.
  assign S_AXI_AWREADY = active && !aw_full && (wr_state != W_RESP);
  assign S_AXI_WREADY  = active && !w_full  && (wr_state != W_RESP);
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_ARREADY = active && (rd_state == R_IDLE);
  assign S_AXI_RVALID  = (rd_state == R_RESP);

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (wr_state == W_COLLECT) && aw_full && w_full;

  assign ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_mapped = (aw_idx[IDX_W-1:2] == '0);
  assign rd_mapped = (ar_idx[IDX_W-1:2] == '0);

`ifdef SS_AXI_SLVERR_EN
  assign wr_resp_code = wr_mapped ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp_code = rd_mapped ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp_code = RESP_OKAY;
  assign rd_resp_code = RESP_OKAY;
`endif

  assign slv_reg0 = regs[0];
  assign slv_reg1 = regs[1];
  assign slv_reg2 = regs[2];
  assign slv_reg3 = regs[3];

  // Select the word a read will capture; unmapped slots read as zero.
  always_comb begin
    rd_word = '0;
    if (rd_mapped) begin
      rd_word = regs[ar_idx[1:0]];
    end
  end

  // Marks the first clock after reset release; gates the readies.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  // State registers for the write and read channel FSMs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Write FSM: collect AW and W in any order, commit, then hold the response.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:    if (aw_hs || w_hs) wr_next = W_COLLECT;
      W_COLLECT: if (commit)        wr_next = W_RESP;
      W_RESP:    if (S_AXI_BREADY)  wr_next = W_IDLE;
      default:                      wr_next = W_IDLE;
    endcase
  end

  // Read FSM: capture on AR handshake, hold data until the master takes it.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)         rd_next = R_RESP;
      R_RESP:  if (S_AXI_RREADY)  rd_next = R_IDLE;
      default:                    rd_next = R_IDLE;
    endcase
  end

  // Address and data latches; both clear on the commit edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // Register bank, per-slot write pulse and write response code.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      reg_wr_pulse <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        S_AXI_BRESP <= wr_resp_code;
        if (wr_mapped) begin
          reg_wr_pulse[aw_idx[1:0]] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) begin
              regs[aw_idx[1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read data and response capture; the register value seen is the one
  // before any commit on the same edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= rd_word;
      S_AXI_RRESP <= rd_resp_code;
    end
  end

endmodule

// File: tb/tb_ss_axi_lite_slave.sv
// tb_ss_axi_lite_slave: self-checking bench for ss_axi_lite_slave with a
// word-array reference model and randomized traffic.
`timescale 1ns/1ps

module tb_ss_axi_lite_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  reg_wr_pulse;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_regs [4];

`ifdef SS_AXI_SLVERR_EN
  localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

  always #5 clk = ~clk;

  ss_axi_lite_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready), .slv_reg0(slv_reg0), .slv_reg1(slv_reg1),
    .slv_reg2(slv_reg2), .slv_reg3(slv_reg3), .reg_wr_pulse(reg_wr_pulse)
  );

  // Reference model: byte merge, slot decode and expected response.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0] strb);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic bit is_mapped(input logic [4:0] addr);
    return (int'(addr) / 4) < 4;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [4:0] addr);
    return is_mapped(addr) ? 2'b00 : UNMAPPED_RESP;
  endfunction

  function automatic logic [3:0] exp_pulse(input logic [4:0] addr);
    return is_mapped(addr) ? 4'(1 << (int'(addr) / 4)) : 4'b0000;
  endfunction

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (is_mapped(addr)) begin
      model_regs[int'(addr) / 4] = merge_bytes(model_regs[int'(addr) / 4], data, strb);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    return is_mapped(addr) ? model_regs[int'(addr) / 4] : 32'h0;
  endfunction

  // Bus driving helpers (observe only; checks live in the test tasks).
  task automatic start_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    awaddr = addr; awprot = 3'($urandom); awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
  endtask

  task automatic wait_hs(output bit to);
    int n;
    bit aw_go, w_go;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1;
      n++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
    end
    to = awvalid || wvalid;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic wait_b(input bit accept, output logic [1:0] resp,
                        output logic [3:0] p_or, output int p_cnt,
                        output int lat, output bit to);
    lat = 0; p_or = 4'b0; p_cnt = 0;
    while (!bvalid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (reg_wr_pulse != 4'b0) begin
        p_or = p_or | reg_wr_pulse;
        p_cnt++;
      end
    end
    to = !bvalid;
    resp = bresp;
    if (accept) begin
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      if (reg_wr_pulse != 4'b0) p_cnt++;
    end
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit to);
    int n;
    bit ar_go;
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1; n = 0;
    while (arvalid && n < 50) begin
      ar_go = arready;
      @(posedge clk); #1;
      n++;
      if (ar_go) arvalid = 1'b0;
    end
    while (!rvalid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    to = arvalid || !rvalid;
    arvalid = 1'b0;
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0;
    arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake got=%b want=0",
               {awready, wready, arready, bvalid, rvalid, bresp, rresp});
    end
    tests_run++;
    if ({rdata, slv_reg0, slv_reg1, slv_reg2, slv_reg3, reg_wr_pulse} !== 164'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data rdata=%h regs=%h %h %h %h pulse=%b want all 0",
               rdata, slv_reg0, slv_reg1, slv_reg2, slv_reg3, reg_wr_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_reset got=%b want=111", {awready, wready, arready});
    end
  endtask

  task automatic test_sequential();
    logic [1:0] resp;
    logic [3:0] p_or;
    logic [31:0] data;
    int p_cnt, lat;
    bit to1, to2;
    for (int i = 0; i < 4; i++) begin
      start_write(5'(i * 4), 32'(i + 1), 4'hF);
      wait_hs(to1);
      wait_b(1'b1, resp, p_or, p_cnt, lat, to2);
      model_write(5'(i * 4), 32'(i + 1), 4'hF);
      tests_run++;
      if ({to1, to2, resp, p_or} !== {2'b00, 2'b00, 4'(1 << i)} || p_cnt != 1 || lat != 1) begin
        tests_failed++;
        $display("[TB] FAIL seq_write%0d to=%b%b resp=%b pulse=%b cnt=%0d lat=%0d want resp=00 pulse=%b cnt=1 lat=1",
                 i, to1, to2, resp, p_or, p_cnt, lat, 4'(1 << i));
      end
    end
    tests_run++;
    if ({slv_reg0, slv_reg1, slv_reg2, slv_reg3} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      tests_failed++;
      $display("[TB] FAIL seq_regs got=%h %h %h %h want=1 2 3 4",
               slv_reg0, slv_reg1, slv_reg2, slv_reg3);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i * 4), data, resp, to1);
      tests_run++;
      if (to1 || data !== 32'(i + 1) || resp !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL seq_read%0d to=%b data=%h resp=%b want data=%h resp=00",
                 i, to1, data, resp, 32'(i + 1));
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    logic [3:0] p_or;
    int p_cnt, lat;
    bit to1, to2, early_b, w_go;
    start_write(5'h04, 32'h11223344, 4'hF);
    wait_hs(to1);
    wait_b(1'b1, resp, p_or, p_cnt, lat, to2);
    model_write(5'h04, 32'h11223344, 4'hF);
    wdata = 32'hDEADBEEF; wstrb = 4'b0101; wvalid = 1'b1; awvalid = 1'b0;
    early_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      w_go = wvalid && wready;
      @(posedge clk); #1;
      if (w_go) wvalid = 1'b0;
      early_b = early_b | bvalid;
    end
    tests_run++;
    if (early_b !== 1'b0 || wvalid !== 1'b0 || slv_reg1 !== 32'h11223344) begin
      tests_failed++;
      $display("[TB] FAIL w_first_wait bvalid_seen=%b w_pending=%b reg1=%h want 0 0 11223344",
               early_b, wvalid, slv_reg1);
    end
    awaddr = 5'h04; awvalid = 1'b1;
    wait_hs(to1);
    wait_b(1'b1, resp, p_or, p_cnt, lat, to2);
    model_write(5'h04, 32'hDEADBEEF, 4'b0101);
    tests_run++;
    if (to1 || to2 || resp !== 2'b00 || slv_reg1 !== 32'h11AD33EF || slv_reg1 !== model_regs[1]) begin
      tests_failed++;
      $display("[TB] FAIL w_first_commit to=%b%b resp=%b reg1=%h want resp=00 reg1=11AD33EF",
               to1, to2, resp, slv_reg1);
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] resp;
    logic [3:0] p_or;
    int p_cnt, lat, stall_bad;
    bit to1, to2;
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    start_write(5'h0C, d1, 4'hF);
    wait_hs(to1);
    wait_b(1'b0, resp, p_or, p_cnt, lat, to2);
    model_write(5'h0C, d1, 4'hF);
    start_write(5'h00, d2, 4'hF);
    stall_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!bvalid || awready || wready || reg_wr_pulse != 4'b0) stall_bad++;
    end
    tests_run++;
    if (to1 || to2 || stall_bad != 0 || slv_reg0 !== model_regs[0] || slv_reg3 !== d1) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold to=%b%b bad_cycles=%0d reg0=%h reg3=%h want 0 reg0=%h reg3=%h",
               to1, to2, stall_bad, slv_reg0, slv_reg3, model_regs[0], d1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_release bvalid=%b want=0", bvalid);
    end
    wait_hs(to1);
    wait_b(1'b1, resp, p_or, p_cnt, lat, to2);
    model_write(5'h00, d2, 4'hF);
    tests_run++;
    if (to1 || to2 || resp !== 2'b00 || p_or !== 4'b0001 || p_cnt != 1 || slv_reg0 !== d2) begin
      tests_failed++;
      $display("[TB] FAIL stall_second to=%b%b resp=%b pulse=%b cnt=%0d reg0=%h want 00 0001 1 %h",
               to1, to2, resp, p_or, p_cnt, slv_reg0, d2);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_val, data;
    logic [1:0] resp;
    bit to;
    old_val = model_regs[2];
    awaddr = 5'h08; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL same_edge_ready got=%b want=111", {awready, wready, arready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h08; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    tests_run++;
    if ({bvalid, rvalid} !== 2'b11 || rdata !== old_val || rresp !== 2'b00 || slv_reg2 !== 32'h5A5A5A5A) begin
      tests_failed++;
      $display("[TB] FAIL same_edge_read bv/rv=%b rdata=%h rresp=%b reg2=%h want 11 %h 00 5A5A5A5A",
               {bvalid, rvalid}, rdata, rresp, slv_reg2, old_val);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    model_write(5'h08, 32'h5A5A5A5A, 4'hF);
    do_read(5'h08, data, resp, to);
    tests_run++;
    if (to || data !== 32'h5A5A5A5A || resp !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL same_edge_reread to=%b data=%h resp=%b want 5A5A5A5A 00", to, data, resp);
    end
  endtask

  task automatic test_unmapped();
    logic [1:0] resp;
    logic [3:0] p_or;
    logic [31:0] data;
    int p_cnt, lat;
    bit to1, to2;
    start_write(5'h10, 32'hFFFFFFFF, 4'hF);
    wait_hs(to1);
    wait_b(1'b1, resp, p_or, p_cnt, lat, to2);
    tests_run++;
    if (to1 || to2 || resp !== UNMAPPED_RESP || p_cnt != 0 ||
        {slv_reg0, slv_reg1, slv_reg2, slv_reg3} !==
        {model_regs[0], model_regs[1], model_regs[2], model_regs[3]}) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_write to=%b%b resp=%b pulses=%0d regs=%h %h %h %h want resp=%b pulses=0 regs unchanged",
               to1, to2, resp, p_cnt, slv_reg0, slv_reg1, slv_reg2, slv_reg3, UNMAPPED_RESP);
    end
    do_read(5'h10, data, resp, to1);
    tests_run++;
    if (to1 || data !== 32'h0 || resp !== UNMAPPED_RESP) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_read to=%b data=%h resp=%b want 0 %b", to1, data, resp, UNMAPPED_RESP);
    end
  endtask

  task automatic test_random();
    logic [4:0] addr;
    logic [31:0] data, got;
    logic [3:0] strb, p_or;
    logic [1:0] resp;
    int p_cnt, lat;
    bit to1, to2;
    for (int n = 0; n < 40; n++) begin
      addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        start_write(addr, data, strb);
        wait_hs(to1);
        wait_b(1'b1, resp, p_or, p_cnt, lat, to2);
        model_write(addr, data, strb);
        tests_run++;
        if (to1 || to2 || resp !== exp_resp(addr) || p_or !== exp_pulse(addr) ||
            p_cnt != (is_mapped(addr) ? 1 : 0) ||
            {slv_reg0, slv_reg1, slv_reg2, slv_reg3} !==
            {model_regs[0], model_regs[1], model_regs[2], model_regs[3]}) begin
          tests_failed++;
          $display("[TB] FAIL rand_write addr=%h strb=%b resp=%b pulse=%b cnt=%0d regs=%h %h %h %h want resp=%b pulse=%b regs=%h %h %h %h",
                   addr, strb, resp, p_or, p_cnt, slv_reg0, slv_reg1, slv_reg2, slv_reg3,
                   exp_resp(addr), exp_pulse(addr),
                   model_regs[0], model_regs[1], model_regs[2], model_regs[3]);
        end
      end else begin
        do_read(addr, got, resp, to1);
        tests_run++;
        if (to1 || got !== model_read(addr) || resp !== exp_resp(addr)) begin
          tests_failed++;
          $display("[TB] FAIL rand_read addr=%h data=%h resp=%b want %h %b",
                   addr, got, resp, model_read(addr), exp_resp(addr));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit to;
    bit b_seen;
    logic [3:0] p_seen;
    awaddr = 5'h04; awvalid = 1'b1; wvalid = 1'b0;
    wait_hs(to);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    tests_run++;
    if (to || {awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_pulse} !== 13'b0 ||
        {rdata, slv_reg0, slv_reg1, slv_reg2, slv_reg3} !== 160'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_reset to=%b hs=%b rdata=%h regs=%h %h %h %h want all 0",
               to, {awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_pulse},
               rdata, slv_reg0, slv_reg1, slv_reg2, slv_reg3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    wait_hs(to);
    b_seen = 1'b0;
    p_seen = 4'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      b_seen = b_seen | bvalid;
      p_seen = p_seen | reg_wr_pulse;
    end
    tests_run++;
    if (to || b_seen !== 1'b0 || p_seen !== 4'b0 ||
        {slv_reg0, slv_reg1, slv_reg2, slv_reg3} !== 128'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_w_alone to=%b bvalid_seen=%b pulse=%b reg1=%h want 0 0 0000 0",
               to, b_seen, p_seen, slv_reg1);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_w_before_aw();
    test_bready_stall();
    test_same_edge();
    test_unmapped();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ss_axi_lite_slave.md
Name: ss_axi_lite_slave

Overview:
AXI4-Lite responder register bank for the SS peripheral. It accepts write and read transactions from the interconnect or VIP master and holds four 32-bit software-visible registers. It exports those registers plus per-register write pulses to the SS display core. It is the slave end of the S00_AXI interface driven by the block-level bench.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots, of which slots 0-3 are mapped.

Ports:
S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
S_AXI_ARESETN  in  1  asynchronous, active-low reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte-lane enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
slv_reg0..slv_reg3  out  32 each  register contents to the SS core.
reg_wr_pulse  out  4  one-cycle pulse; bit i marks a commit to slot i.

Behaviour:
- Reset (async assert, sync release): all READY/VALID = 0, BRESP = RRESP = 2'b00, RDATA = 0, slv_reg0..3 = 0, reg_wr_pulse = 0, internal latches cleared. A reset asserted mid-transaction aborts it: no response is issued and no partial register update occurs.
- Word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
- Write channel, 3 states: IDLE, COLLECT, RESP.
  - AW and W are accepted independently. AWREADY=1 while no address is latched and BVALID=0; WREADY=1 while no data is latched and BVALID=0.
  - A handshake latches address or data+strb. AW and W in the same cycle are legal, and either order is legal.
  - The first edge where both are latched is the commit edge. At that edge: for each lane with WSTRB[b]=1, byte b of the target register is updated; BVALID←1; BRESP←OKAY; reg_wr_pulse[idx]←1 for exactly one cycle. The pulse fires even when WSTRB=0. Latches clear.
  - Latency: AW and W together at edge k → write committed and BVALID high after edge k+1.
  - BVALID holds until the BREADY edge. No AW or W is accepted while BVALID=1.
  - Unmapped slots 4-7: no register changes, no pulse, BRESP=OKAY.
- Read channel, 2 states: IDLE, RESP.
  - ARREADY=1 iff RVALID=0. On the AR handshake edge: RDATA←selected register (unmapped reads return 0), RRESP←OKAY, RVALID←1.
  - RDATA and RVALID hold until the RREADY edge. The next AR is accepted no earlier than the cycle after RVALID falls.
  - Read and write channels run fully concurrently.
  - A write commit and a read capture of the same register on the same edge: the read returns the pre-write value.
- Outputs slv_regN change only on commit edges.

Optional Feature:
SS_AXI_SLVERR_EN
- Defined: any access to slots 4-7 responds SLVERR (2'b10) on BRESP or RRESP. Reads still return RDATA=0. Writes still have no side effects.
- Undefined: unmapped accesses respond OKAY as described above.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then reads in order → reads return 0x1..0x4 with RRESP=OKAY; slv_reg0..3 = 1..4; reg_wr_pulse pulses 0001, 0010, 0100, 1000 once each.
- W presented 3 cycles before AW (0x04, data 0xDEADBEEF, WSTRB=4'b0101) on reg preset to 0x11223344 → no BVALID until AW is taken; then slv_reg1 = 0x11AD33EF, BRESP=OKAY.
- BREADY held low 10 cycles after a write → BVALID stays 1; AWREADY and WREADY stay 0; a second AW/W is stalled and completes only after the BREADY handshake.
- Write 0x5A5A5A5A to 0x08 and read 0x08 with the commit and AR handshake on the same edge → RDATA = old value; a following read returns 0x5A5A5A5A.
- Access 0x10 (write 0xFFFFFFFF, then read) → registers unchanged, RDATA=0; RESP=OKAY, or SLVERR with SS_AXI_SLVERR_EN defined.
- Assert S_AXI_ARESETN low while AW is latched but W is pending → all outputs 0 immediately; after release, the W alone produces no BVALID.
